// File: rtl/io_pkg.sv
// ============================================================================
// io_pkg -- load/store encodings and offsets shared by the memory-mapped I/O peripherals
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package io_pkg;

  // funct3 encodings for loads and stores, also used by the store peripheral
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte offsets of the input peripheral words
  localparam int IN_SW_OFS  = 0;
  localparam int IN_BTN_OFS = 4;
  localparam int IN_EVT_OFS = 8;

  // Number of bytes touched by an access; every non-byte, non-half code is a word
  function automatic logic [2:0] access_bytes(input logic [2:0] f3);
    logic [2:0] n;
    case (f3[1:0])
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// btn_debounce -- 2-flop synchronizer and stable-count debouncer for one active-low button
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n,
  output logic state,
  output logic rise
);

  localparam int C_CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [C_CW-1:0] C_LAST = C_CW'(DEBOUNCE_CYCLES - 1);

  logic            r_meta;
  logic            r_sync;
  logic            r_state;
  logic [C_CW-1:0] r_cnt;

  logic w_pressed;
  logic w_differ;
  logic w_accept;

  assign w_pressed = ~r_sync;
  assign w_differ  = w_pressed ^ r_state;
  assign w_accept  = w_differ && (r_cnt == C_LAST);

  // Sync flops reset to the released level so no false press follows reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_meta  <= 1'b1;
      r_sync  <= 1'b1;
      r_state <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= btn_n;
      r_sync <= r_meta;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_state <= w_pressed;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign state = r_state;
  assign rise  = w_accept & w_pressed;

endmodule

`default_nettype wire

// File: rtl/io_input_reader.sv
// ============================================================================
// io_input_reader -- memory-mapped switch/button input peripheral with sticky press events
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module io_input_reader
  import io_pkg::*;
#(
  parameter int SW_WIDTH        = 17,
  parameter int BTN_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [SW_WIDTH-1:0]  i_io_sw,
  input  logic [BTN_WIDTH-1:0] i_io_btn,
  input  logic                 ld_en,
  input  logic [2:0]           funct3,
  input  logic [3:0]           addr,
  output logic [31:0]          ld_data
);

  logic [SW_WIDTH-1:0]  r_sw_meta;
  logic [SW_WIDTH-1:0]  r_sw_sync;
  logic [BTN_WIDTH-1:0] r_evt;

  logic [BTN_WIDTH-1:0] w_btn_state;
  logic [BTN_WIDTH-1:0] w_btn_rise;
  logic [BTN_WIDTH-1:0] w_evt_clr;

  logic [31:0] w_sw_word;
  logic [31:0] w_btn_word;
  logic [31:0] w_evt_word;
  logic [4:0]  w_lo;
  logic [4:0]  w_hi;
  logic [7:0]  w_map [16];
  logic [7:0]  w_b   [4];
  logic [31:0] w_fmt;

  // Offsets are carried in 5 bits so an access near 0xF reads zeros instead of wrapping
  assign w_lo = {1'b0, addr};
  assign w_hi = w_lo + {2'b00, access_bytes(funct3)} - 5'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= i_io_sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  generate
    for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_btn
      localparam logic [4:0] c_evt_byte = 5'(IN_EVT_OFS + i / 8);

      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .btn_n (i_io_btn[i]),
        .state (w_btn_state[i]),
        .rise  (w_btn_rise[i])
      );

      assign w_evt_clr[i] = ld_en && (c_evt_byte >= w_lo) && (c_evt_byte <= w_hi);
    end
  endgenerate

  // A press landing on the same edge as a clearing read must not be lost
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_evt <= '0;
    end else begin
      r_evt <= (r_evt & ~w_evt_clr) | w_btn_rise;
    end
  end

  assign w_sw_word  = 32'(r_sw_sync);
  assign w_btn_word = 32'(w_btn_state);
  assign w_evt_word = 32'(r_evt);

  always_comb begin
    for (int j = 0; j < 16; j++) begin
      w_map[j] = 8'h00;
    end
    for (int j = 0; j < 4; j++) begin
      w_map[IN_SW_OFS + j]  = w_sw_word[8*j +: 8];
      w_map[IN_BTN_OFS + j] = w_btn_word[8*j +: 8];
      w_map[IN_EVT_OFS + j] = w_evt_word[8*j +: 8];
    end
  end

  always_comb begin
    logic [4:0] ofs;
    for (int k = 0; k < 4; k++) begin
      ofs    = w_lo + 5'(k);
      w_b[k] = ofs[4] ? 8'h00 : w_map[ofs[3:0]];
    end
  end

  always_comb begin
    case (funct3)
      F3_B:    w_fmt = {{24{w_b[0][7]}}, w_b[0]};
      F3_BU:   w_fmt = {24'h000000, w_b[0]};
      F3_H:    w_fmt = {{16{w_b[1][7]}}, w_b[1], w_b[0]};
      F3_HU:   w_fmt = {16'h0000, w_b[1], w_b[0]};
      default: w_fmt = {w_b[3], w_b[2], w_b[1], w_b[0]};
    endcase
  end

  assign ld_data = rst_i ? 32'h0000_0000 : w_fmt;

endmodule

`default_nettype wire

// File: tb/tb_io_input_reader.sv
// ============================================================================
// tb_io_input_reader -- directed and randomized checks of io_input_reader against a reference model
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_io_input_reader;

  localparam int SW_W = 17;
  localparam int BTN_W = 4;
  localparam int DC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [SW_W-1:0]   sw;
  logic [BTN_W-1:0]  btn;
  logic              ld_en;
  logic [2:0]        f3;
  logic [3:0]        addr;
  logic [31:0]       ld_data;

  int n_checks = 0;
  int n_fail   = 0;

  io_input_reader #(
    .SW_WIDTH(SW_W),
    .BTN_WIDTH(BTN_W),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .i_io_sw (sw),
    .i_io_btn(btn),
    .ld_en   (ld_en),
    .funct3  (f3),
    .addr    (addr),
    .ld_data (ld_data)
  );

  always #5 clk = ~clk;

  // Reference model: sampled pipelines, per-button run length of disagreeing samples
  logic [31:0]      m_sw;
  logic [SW_W-1:0]  m_s1;
  logic [BTN_W-1:0] m_b1, m_b2;
  logic [BTN_W-1:0] m_st, m_ev;
  int               m_run [BTN_W];

  function automatic int n_bytes(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sw <= 0; m_s1 <= 0; m_b1 <= '1; m_b2 <= '1; m_st <= 0; m_ev <= 0;
      for (int i = 0; i < BTN_W; i++) m_run[i] <= 0;
    end else begin : mdl
      logic [BTN_W-1:0] st, ev, rs;
      int run [BTN_W];
      int lo, hi;
      st = m_st; ev = m_ev; rs = 0;
      for (int i = 0; i < BTN_W; i++) begin
        logic p;
        p = ~m_b2[i];
        run[i] = m_run[i];
        if (p == st[i]) run[i] = 0;
        else begin
          run[i] = run[i] + 1;
          if (run[i] == DC) begin
            st[i] = p; run[i] = 0;
            if (p) rs[i] = 1'b1;
          end
        end
      end
      if (ld_en) begin
        lo = int'(addr);
        hi = lo + n_bytes(f3) - 1;
        for (int i = 0; i < BTN_W; i++)
          if (8 + i / 8 >= lo && 8 + i / 8 <= hi) ev[i] = 1'b0;
      end
      ev = ev | rs;
      m_st <= st; m_ev <= ev;
      for (int i = 0; i < BTN_W; i++) m_run[i] <= run[i];
      m_sw <= 32'(m_s1); m_s1 <= sw;
      m_b2 <= m_b1; m_b1 <= btn;
    end
  end

  function automatic logic [7:0] map_byte(input int o);
    logic [31:0] w;
    if (o < 4)       w = m_sw >> (8 * o);
    else if (o < 8)  w = 32'(m_st) >> (8 * (o - 4));
    else if (o < 12) w = 32'(m_ev) >> (8 * (o - 8));
    else             w = 0;
    return w[7:0];
  endfunction

  function automatic logic [31:0] model_ld(input logic [2:0] f, input logic [3:0] a);
    logic [31:0] v;
    int sz;
    if (rst) return 32'h0;
    sz = n_bytes(f);
    v = 0;
    for (int k = 0; k < sz; k++) v = v | (32'(map_byte(int'(a) + k)) << (8 * k));
    if (sz < 4 && !f[2] && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic rd(input string tag, input logic [2:0] f, input logic [3:0] a,
                    input logic en, input logic [31:0] exp);
    f3 = f; addr = a; ld_en = en;
    #1;
    check(tag, ld_data, exp);
  endtask

  task automatic step();
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sw = 17'h1FFFF; btn = 4'h0; ld_en = 1'b0; f3 = 3'd2; addr = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rd("rst_lw0", 3'd2, 4'h0, 1'b0, 32'h0);
    rd("rst_lw4", 3'd2, 4'h4, 1'b0, 32'h0);
    rd("rst_lw8", 3'd2, 4'h8, 1'b0, 32'h0);
    rd("rst_lb1", 3'd0, 4'h1, 1'b0, 32'h0);
    rst = 1'b0; btn = 4'hF;
    step();
    rd("sw_1edge", 3'd2, 4'h0, 1'b0, 32'h0);
    step();
    rd("sw_2edge", 3'd2, 4'h0, 1'b0, 32'h0001_FFFF);

    sw = 17'h00080; step(); step();
    rd("lb_neg", 3'd0, 4'h0, 1'b0, 32'hFFFF_FF80);
    rd("lbu", 3'd4, 4'h0, 1'b0, 32'h0000_0080);
    sw = 17'h18000; step(); step();
    rd("lh_neg", 3'd1, 4'h0, 1'b0, 32'hFFFF_8000);
    rd("lhu", 3'd5, 4'h0, 1'b0, 32'h0000_8000);
    rd("lb2", 3'd0, 4'h2, 1'b0, 32'h0000_0001);
    rd("lw_f3_7", 3'd7, 4'h0, 1'b0, 32'h0001_8000);

    // Bounce on btn[1]: pressed 3, released 1, pressed 3, then released
    begin
      logic [14:0] pat;
      pat = 15'b111_0_111_00000000;
      for (int c = 14; c >= 0; c--) begin
        btn = pat[c] ? 4'hD : 4'hF;
        rd("bounce_st", 3'd2, 4'h4, 1'b0, 32'h0);
        rd("bounce_ev", 3'd2, 4'h8, 1'b0, 32'h0);
        step();
      end
    end

    btn = 4'hB;
    for (int k = 1; k <= 8; k++) begin
      step();
      rd("press_lat", 3'd2, 4'h4, 1'b0, (k >= 6) ? 32'h4 : 32'h0);
    end
    rd("press_ev", 3'd2, 4'h8, 1'b0, 32'h4);
    btn = 4'hF;
    repeat (10) step();
    rd("release_st", 3'd2, 4'h4, 1'b0, 32'h0);
    rd("sticky_ev", 3'd2, 4'h8, 1'b0, 32'h4);

    rd("cor_read", 3'd4, 4'h8, 1'b1, 32'h04);
    step();
    rd("cor_clr", 3'd4, 4'h8, 1'b0, 32'h0);
    btn = 4'hB;
    repeat (5) step();
    rd("cor_pre", 3'd4, 4'h8, 1'b1, 32'h0);
    step();
    rd("set_wins", 3'd4, 4'h8, 1'b0, 32'h04);
    rd("lb9_clr", 3'd4, 4'h9, 1'b1, 32'h0);
    step();
    rd("lb9_noclr", 3'd4, 4'h8, 1'b0, 32'h04);

    rd("clr_again", 3'd4, 4'h8, 1'b1, 32'h04);
    step();
    rd("lw_a", 3'd2, 4'hA, 1'b0, 32'h0);
    rd("lw_3", 3'd2, 4'h3, 1'b0, 32'h0000_0400);
    rd("lw_e", 3'd2, 4'hE, 1'b0, 32'h0);
    rd("lh_b", 3'd1, 4'hB, 1'b0, 32'h0);
    rd("lw_f", 3'd2, 4'hF, 1'b0, 32'h0);
    btn = 4'hF;
    repeat (10) step();

    // Reset while btn[0] is part way through its debounce count
    btn = 4'hE;
    repeat (5) step();
    rst = 1'b1;
    rd("midrst_rd", 3'd2, 4'h0, 1'b0, 32'h0);
    step();
    rst = 1'b0;
    repeat (3) step();
    rd("midrst_st", 3'd2, 4'h4, 1'b0, 32'h0);
    btn = 4'hF;
    repeat (10) step();

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      if ($urandom_range(0, 3) == 0) sw = SW_W'($urandom);
      if ($urandom_range(0, 9) == 0) btn[$urandom_range(0, BTN_W - 1)] ^= 1'b1;
      ld_en = ($urandom_range(0, 2) == 0);
      f3    = 3'($urandom);
      addr  = 4'($urandom);
      #1;
      check("rnd", ld_data, model_ld(f3, addr));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
